instr_fetcher: RTL and testbench
================================

Name: instr_fetcher

Overview:
- Per-core instruction fetch unit.
- Takes the program counter that the program-counter logic committed in EXECUTE (current_pc) and fetches the 16-bit instruction word from program memory.
- Uses a valid/ready read handshake with the program-memory controller.
- Holds the instruction for the decoder and keeps a single-entry last-fetch buffer. Tight loops that re-fetch the same address (e.g. a BRnzp branch to itself) do not re-hit memory.

Parameters:
PROGRAM_MEM_ADDR_BITS, 8, program memory address width (matches PC width)
PROGRAM_MEM_DATA_BITS, 16, instruction word width

Ports:
clk  input  1  core clock
reset  input  1  asynchronous, active-high reset
core_state  input  3  core FSM state: 000 IDLE, 001 FETCH, 010 DECODE, 011 REQUEST, 100 WAIT, 101 EXECUTE, 110 UPDATE, 111 DONE
current_pc  input  PROGRAM_MEM_ADDR_BITS  address to fetch
invalidate  input  1  clears last-fetch buffer (asserted at kernel launch)
mem_read_valid  output  1  read request to program memory
mem_read_address  output  PROGRAM_MEM_ADDR_BITS  request address
mem_read_ready  input  1  memory response strobe, data valid same cycle
mem_read_data  input  PROGRAM_MEM_DATA_BITS  instruction word
fetcher_state  output  3  000 IDLE, 001 FETCHING, 010 FETCHED
instruction  output  PROGRAM_MEM_DATA_BITS  fetched instruction, stable in FETCHED and until next capture

Behaviour:
- Clock and reset: one clock domain, clk. Reset is asynchronous and active-high; all registers clear on posedge reset, independent of clk.
- Reset values:
  - fetcher_state=IDLE, mem_read_valid=0, mem_read_address=0, instruction=0.
  - Internal buf_valid=0, buf_addr=0.
- IDLE:
  - Leaves IDLE only when core_state==FETCH.
  - Hit (buf_valid && buf_addr==current_pc): next state FETCHED; instruction unchanged; mem_read_valid stays 0.
  - Miss: next state FETCHING; mem_read_valid<=1; mem_read_address<=current_pc.
- FETCHING:
  - mem_read_valid stays high and mem_read_address stays stable until mem_read_ready is sampled 1.
  - On the mem_read_ready cycle: instruction<=mem_read_data; buf_addr<=mem_read_address; buf_valid<=1; mem_read_valid<=0; next state FETCHED.
  - mem_read_ready while mem_read_valid==0 is ignored.
- FETCHED:
  - Holds until core_state==DECODE, then returns to IDLE.
  - instruction is held through IDLE until the next capture.
- Latency:
  - Miss: request visible 1 cycle after FETCH is first sampled. FETCHED is visible the cycle after mem_read_ready.
  - Hit: FETCHED is visible 1 cycle after FETCH is sampled.
- invalidate:
  - Sampled every cycle; sets buf_valid<=0.
  - Has priority over a buffer fill in the same cycle: the instruction is still captured, buf_valid ends 0.
  - An invalidate in the same cycle as an IDLE hit check forces a miss.
- core_state values other than FETCH/DECODE leave the fetcher FSM unchanged.
- Any undefined fetcher_state encoding returns to IDLE next cycle with mem_read_valid=0.
- Reset mid-FETCHING drops the request immediately, asynchronously. The memory controller must tolerate valid falling without a ready.
- No branch prediction or prefetch. At most one outstanding request.

Test Plan:
1. Reset during FETCHING (mem_read_valid=1, addr 0x05) -> mem_read_valid=0, fetcher_state=IDLE, instruction=0 immediately, before the next clk edge.
2. Miss:
   - Stimulus: core_state=FETCH, current_pc=0x12, memory returns 0xA3C4 with ready after 3 cycles.
   - Response: mem_read_valid=1, addr=0x12 held stable for 3 cycles. Next cycle fetcher_state=FETCHED, instruction=0xA3C4.
   - Then core_state=DECODE -> IDLE.
3. Hit:
   - Stimulus: after scenario 2, FETCH again with current_pc=0x12.
   - Response: FETCHED after 1 cycle, mem_read_valid never asserted, instruction=0xA3C4.
4. Miss after a different address:
   - Stimulus: FETCH with current_pc=0x13 after buffer holds 0x12; memory returns 0x1111.
   - Response: new request to 0x13; instruction=0x1111; a later fetch of 0x12 misses.
5. Invalidate vs fill:
   - Stimulus: invalidate=1 on the same cycle as mem_read_ready for addr 0x20, data 0xBEEF.
   - Response: instruction=0xBEEF. A subsequent FETCH of 0x20 issues a new memory request.
6. Stray ready and hold in FETCHED:
   - Stimulus: pulse mem_read_ready=1 while IDLE; hold core_state=FETCH in FETCHED for 4 cycles.
   - Response: no state change and no capture on the stray ready; the fetcher remains FETCHED with instruction stable.

Source files
------------

// File: rtl/instr_fetcher.sv
// Instruction fetch unit: valid/ready read of program memory
// with a single-entry last-fetch buffer that short-circuits repeat fetches.
module instr_fetcher #(
  parameter int PROGRAM_MEM_ADDR_BITS = 8,
  parameter int PROGRAM_MEM_DATA_BITS = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [2:0]                       core_state,
  input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
  input  logic                             invalidate,
  output logic                             mem_read_valid,
  output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
  input  logic                             mem_read_ready,
  input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
  output logic [2:0]                       fetcher_state,
  output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction
);

  localparam logic [2:0] CORE_FETCH  = 3'b001;
  localparam logic [2:0] CORE_DECODE = 3'b010;

  typedef enum logic [2:0] {
    S_IDLE     = 3'b000,
    S_FETCHING = 3'b001,
    S_FETCHED  = 3'b010
  } state_t;

  state_t r_state;
  state_t w_state_nx;

  logic                             r_valid;
  logic [PROGRAM_MEM_ADDR_BITS-1:0] r_addr;
  logic [PROGRAM_MEM_DATA_BITS-1:0] r_instr;
  logic                             r_buf_valid;
  logic [PROGRAM_MEM_ADDR_BITS-1:0] r_buf_addr;

  logic                             w_valid_nx;
  logic [PROGRAM_MEM_ADDR_BITS-1:0] w_addr_nx;
  logic [PROGRAM_MEM_DATA_BITS-1:0] w_instr_nx;
  logic                             w_buf_valid_nx;
  logic [PROGRAM_MEM_ADDR_BITS-1:0] w_buf_addr_nx;
  logic                             w_hit;

  // A same-cycle invalidate kills the hit so the word is re-read.
  assign w_hit = r_buf_valid && (r_buf_addr == current_pc) && !invalidate;

  assign mem_read_valid   = r_valid;
  assign mem_read_address = r_addr;
  assign fetcher_state    = r_state;
  assign instruction      = r_instr;

  // State register; reset drops the FSM to IDLE at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nx;
  end

  // Request, instruction and buffer registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid     <= 1'b0;
      r_addr      <= '0;
      r_instr     <= '0;
      r_buf_valid <= 1'b0;
      r_buf_addr  <= '0;
    end else begin
      r_valid     <= w_valid_nx;
      r_addr      <= w_addr_nx;
      r_instr     <= w_instr_nx;
      r_buf_valid <= w_buf_valid_nx;
      r_buf_addr  <= w_buf_addr_nx;
    end
  end

  // Next-state and datapath updates; invalidate overrides any fill.
  always_comb begin
    w_state_nx     = r_state;
    w_valid_nx     = r_valid;
    w_addr_nx      = r_addr;
    w_instr_nx     = r_instr;
    w_buf_valid_nx = r_buf_valid;
    w_buf_addr_nx  = r_buf_addr;
    case (r_state)
      S_IDLE: begin
        if (core_state == CORE_FETCH) begin
          if (w_hit) begin
            w_state_nx = S_FETCHED;
          end else begin
            w_state_nx = S_FETCHING;
            w_valid_nx = 1'b1;
            w_addr_nx  = current_pc;
          end
        end
      end
      S_FETCHING: begin
        if (r_valid && mem_read_ready) begin
          w_instr_nx     = mem_read_data;
          w_buf_addr_nx  = r_addr;
          w_buf_valid_nx = 1'b1;
          w_valid_nx     = 1'b0;
          w_state_nx     = S_FETCHED;
        end
      end
      S_FETCHED: begin
        if (core_state == CORE_DECODE) w_state_nx = S_IDLE;
      end
      default: begin
        w_state_nx = S_IDLE;
        w_valid_nx = 1'b0;
      end
    endcase
    if (invalidate) w_buf_valid_nx = 1'b0;
  end

endmodule

// File: tb/tb_instr_fetcher.sv
// Directed-vector bench for instr_fetcher.
// Expected values are hand-derived constants.
module tb_instr_fetcher;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  core_state;
  logic [7:0]  current_pc;
  logic        invalidate;
  logic        mem_read_valid;
  logic [7:0]  mem_read_address;
  logic        mem_read_ready;
  logic [15:0] mem_read_data;
  logic [2:0]  fetcher_state;
  logic [15:0] instruction;

  int n_tot = 0;
  int n_bad = 0;

  localparam logic [2:0] C_IDLE   = 3'b000;
  localparam logic [2:0] C_FETCH  = 3'b001;
  localparam logic [2:0] C_DECODE = 3'b010;
  localparam logic [2:0] F_IDLE   = 3'b000;
  localparam logic [2:0] F_ING    = 3'b001;
  localparam logic [2:0] F_ED     = 3'b010;

  instr_fetcher dut (
    .clk              (clk),
    .reset            (reset),
    .core_state       (core_state),
    .current_pc       (current_pc),
    .invalidate       (invalidate),
    .mem_read_valid   (mem_read_valid),
    .mem_read_address (mem_read_address),
    .mem_read_ready   (mem_read_ready),
    .mem_read_data    (mem_read_data),
    .fetcher_state    (fetcher_state),
    .instruction      (instruction)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_st(input string tag,
                        input logic [2:0] st,
                        input logic v,
                        input logic [15:0] ins);
    chk({tag, ".state"}, 32'(fetcher_state), 32'(st));
    chk({tag, ".valid"}, 32'(mem_read_valid), 32'(v));
    chk({tag, ".instr"}, 32'(instruction), 32'(ins));
  endtask

  initial begin
    reset          = 1'b1;
    core_state     = C_IDLE;
    current_pc     = 8'h00;
    invalidate     = 1'b0;
    mem_read_ready = 1'b0;
    mem_read_data  = 16'h0000;
    step();
    step();
    chk_st("rst", F_IDLE, 1'b0, 16'h0000);
    chk("rst.addr", 32'(mem_read_address), 32'h0);
    reset = 1'b0;

    // 1: reset in the middle of FETCHING
    core_state = C_FETCH;
    current_pc = 8'h05;
    step();
    chk_st("t1.req", F_ING, 1'b1, 16'h0000);
    chk("t1.addr", 32'(mem_read_address), 32'h05);
    #2 reset = 1'b1;
    #1;
    chk_st("t1.async", F_IDLE, 1'b0, 16'h0000);
    chk("t1.addr0", 32'(mem_read_address), 32'h0);
    #1 reset = 1'b0;
    core_state = C_IDLE;
    step();

    // 2: miss on 0x12, ready after 3 wait cycles
    core_state = C_FETCH;
    current_pc = 8'h12;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_st("t2.wait", F_ING, 1'b1, 16'h0000);
      chk("t2.addr", 32'(mem_read_address), 32'h12);
    end
    mem_read_ready = 1'b1;
    mem_read_data  = 16'hA3C4;
    step();
    mem_read_ready = 1'b0;
    mem_read_data  = 16'h0000;
    chk_st("t2.done", F_ED, 1'b0, 16'hA3C4);
    core_state = C_DECODE;
    step();
    chk_st("t2.dec", F_IDLE, 1'b0, 16'hA3C4);

    // 3: hit on 0x12
    core_state = C_FETCH;
    current_pc = 8'h12;
    step();
    chk_st("t3.hit", F_ED, 1'b0, 16'hA3C4);
    core_state = C_DECODE;
    step();
    chk_st("t3.dec", F_IDLE, 1'b0, 16'hA3C4);

    // 4: miss on 0x13, then 0x12 misses again
    core_state = C_FETCH;
    current_pc = 8'h13;
    step();
    chk_st("t4.req", F_ING, 1'b1, 16'hA3C4);
    chk("t4.addr", 32'(mem_read_address), 32'h13);
    mem_read_ready = 1'b1;
    mem_read_data  = 16'h1111;
    step();
    mem_read_ready = 1'b0;
    chk_st("t4.done", F_ED, 1'b0, 16'h1111);
    core_state = C_DECODE;
    step();
    core_state = C_FETCH;
    current_pc = 8'h12;
    step();
    chk_st("t4.remiss", F_ING, 1'b1, 16'h1111);
    chk("t4.readdr", 32'(mem_read_address), 32'h12);
    mem_read_ready = 1'b1;
    mem_read_data  = 16'hA3C4;
    step();
    mem_read_ready = 1'b0;
    chk_st("t4.refill", F_ED, 1'b0, 16'hA3C4);
    core_state = C_DECODE;
    step();

    // 5: invalidate on the fill cycle of 0x20
    core_state = C_FETCH;
    current_pc = 8'h20;
    step();
    chk("t5.addr", 32'(mem_read_address), 32'h20);
    mem_read_ready = 1'b1;
    mem_read_data  = 16'hBEEF;
    invalidate     = 1'b1;
    step();
    mem_read_ready = 1'b0;
    invalidate     = 1'b0;
    chk_st("t5.fill", F_ED, 1'b0, 16'hBEEF);
    core_state = C_DECODE;
    step();
    core_state = C_FETCH;
    step();
    chk_st("t5.remiss", F_ING, 1'b1, 16'hBEEF);
    chk("t5.readdr", 32'(mem_read_address), 32'h20);
    mem_read_ready = 1'b1;
    step();
    mem_read_ready = 1'b0;
    core_state = C_DECODE;
    step();
    chk_st("t5.idle", F_IDLE, 1'b0, 16'hBEEF);

    // 6: stray ready in IDLE, then hold in FETCHED
    core_state     = C_IDLE;
    mem_read_ready = 1'b1;
    mem_read_data  = 16'h5555;
    step();
    mem_read_ready = 1'b0;
    chk_st("t6.stray", F_IDLE, 1'b0, 16'hBEEF);
    core_state = C_FETCH;
    step();
    chk_st("t6.hit", F_ED, 1'b0, 16'hBEEF);
    mem_read_data = 16'h7777;
    for (int i = 0; i < 4; i++) begin
      mem_read_ready = (i == 1);
      step();
      chk_st("t6.hold", F_ED, 1'b0, 16'hBEEF);
    end
    mem_read_ready = 1'b0;
    core_state = C_DECODE;
    step();
    chk_st("t6.dec", F_IDLE, 1'b0, 16'hBEEF);

    // 7: invalidate coinciding with a would-be hit forces a miss
    core_state = C_FETCH;
    current_pc = 8'h20;
    invalidate = 1'b1;
    step();
    invalidate = 1'b0;
    chk_st("t7.miss", F_ING, 1'b1, 16'hBEEF);
    chk("t7.addr", 32'(mem_read_address), 32'h20);
    mem_read_ready = 1'b1;
    mem_read_data  = 16'hC0DE;
    step();
    mem_read_ready = 1'b0;
    chk_st("t7.done", F_ED, 1'b0, 16'hC0DE);
    core_state = C_DECODE;
    step();
    chk_st("t7.dec", F_IDLE, 1'b0, 16'hC0DE);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
